// File: rtl/nbj_inst_queue.sv
// nbj_inst_queue: fetch-side circular instruction queue, 8-slot enqueue, 2-entry in-order dequeue (optional NBJ_QUEUE_CHECK_EN adds sticky o_error)
module nbj_inst_queue #(
  parameter int DEPTH = 16,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inValid,
  output logic          o_inReady,
  input  logic [511:0]  i_alignedInstructionTableBus_512,
  input  logic [7:0]    i_cutPosition_8,
  input  logic          i_clear,
  output logic [1:0]    o_outValid_2,
  output logic [127:0]  o_outEntry_128,
  input  logic [1:0]    i_deqCount_2,
  output logic [CW-1:0] o_count
`ifdef NBJ_QUEUE_CHECK_EN
  ,
  output logic          o_error
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wPtr, rPtr;
  logic [CW-1:0] count;
  logic [3:0] keepN;
  logic run, enq;
  logic [1:0] avail, deqEff;
  // keep count = length of the run of ones starting at slot 0
  always_comb begin
    keepN = '0;
    run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run = run & i_cutPosition_8[k];
      keepN = keepN + {3'b0, run};
    end
  end
  // readiness and validity come from registered count only; clear blocks acceptance
  always_comb begin
    o_inReady = (count <= CW'(DEPTH - 8)) & ~i_clear;
    enq = i_inValid & o_inReady;
    o_outValid_2 = {count >= CW'(2), count != '0};
    avail = {1'b0, o_outValid_2[0]} + {1'b0, o_outValid_2[1]};
    deqEff = (i_deqCount_2 > avail) ? avail : i_deqCount_2;
    o_outEntry_128 = {o_outValid_2[1] ? mem[rPtr + AW'(1)] : 64'd0,
                      o_outValid_2[0] ? mem[rPtr] : 64'd0};
    o_count = count;
  end
  // write surviving slots into consecutive entries; storage is not reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++)
      if (enq && (4'(k) < keepN))
        mem[wPtr + AW'(k)] <= i_alignedInstructionTableBus_512[64*k +: 64];
  end
  // pointer and occupancy update; clear overrides enqueue and dequeue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wPtr <= '0;
      rPtr <= '0;
      count <= '0;
    end else if (i_clear) begin
      wPtr <= '0;
      rPtr <= '0;
      count <= '0;
    end else begin
      wPtr <= wPtr + (enq ? AW'(keepN) : '0);
      rPtr <= rPtr + AW'(deqEff);
      count <= count + (enq ? CW'(keepN) : '0) - CW'(deqEff);
    end
  end
`ifdef NBJ_QUEUE_CHECK_EN
  // sticky flag for a dequeue request exceeding the valid entries; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_error <= 1'b0;
    else if (i_deqCount_2 > avail) o_error <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_nbj_inst_queue.sv
// tb_nbj_inst_queue: directed self-checking bench for nbj_inst_queue (DEPTH=16)
module tb_nbj_inst_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inValid = 1'b0;
  logic inReady;
  logic [511:0] bus = '0;
  logic [7:0] cut = '0;
  logic clear = 1'b0;
  logic [1:0] outValid;
  logic [127:0] outEntry;
  logic [1:0] deq = '0;
  logic [4:0] count;
  int errs = 0;
  int checks = 0;
  logic [31:0] expPc;
`ifdef NBJ_QUEUE_CHECK_EN
  logic error;
`endif

  nbj_inst_queue #(.DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .i_inValid(inValid),
    .o_inReady(inReady),
    .i_alignedInstructionTableBus_512(bus),
    .i_cutPosition_8(cut),
    .i_clear(clear),
    .o_outValid_2(outValid),
    .o_outEntry_128(outEntry),
    .i_deqCount_2(deq),
    .o_count(count)
`ifdef NBJ_QUEUE_CHECK_EN
    ,
    .o_error(error)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    inValid = 1'b0;
    deq = 2'd0;
    clear = 1'b0;
    cut = 8'd0;
  endtask

  task automatic load(input logic [31:0] base, input logic [7:0] c, input logic [1:0] d);
    for (int k = 0; k < 8; k++) bus[64*k +: 64] = {base + 32'(4*k), 32'hA000_0000 + 32'(k)};
    inValid = 1'b1;
    cut = c;
    deq = d;
  endtask

  task automatic push(input logic [31:0] base, input logic [7:0] c, input logic [1:0] d);
    load(base, c, d);
    step();
  endtask

  task automatic pop(input logic [1:0] d);
    deq = d;
    step();
  endtask

  initial begin
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(outValid), 64'd0);
    chk("rst_entry", outEntry[63:0], 64'd0);
    chk("rst_ready", 64'(inReady), 64'd1);
    @(negedge clk) rst = 1'b1;

    push(32'h100, 8'b0000_0111, 2'd0);
    chk("basic_count", 64'(count), 64'd3);
    chk("basic_valid", 64'(outValid), 64'd3);
    chk("basic_e0", outEntry[63:0], {32'h100, 32'hA000_0000});
    chk("basic_e1pc", 64'(outEntry[127:96]), 64'h104);
    pop(2'd2);
    chk("deq2_count", 64'(count), 64'd1);
    chk("deq2_valid", 64'(outValid), 64'd1);
    chk("deq2_e0pc", 64'(outEntry[63:32]), 64'h108);
    chk("deq2_e1", outEntry[127:64], 64'd0);
    pop(2'd1);
    chk("empty_count", 64'(count), 64'd0);

    push(32'h200, 8'hFF, 2'd0);
    chk("fill8_count", 64'(count), 64'd8);
    chk("fill8_ready", 64'(inReady), 64'd1);
    push(32'h220, 8'hFF, 2'd0);
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(inReady), 64'd0);
    push(32'h900, 8'hFF, 2'd0);
    chk("full_reject", 64'(count), 64'd16);
    for (int j = 1; j <= 8; j++) begin
      pop(2'd2);
      chk("drain_count", 64'(count), 64'(16 - 2*j));
      chk("drain_ready", 64'(inReady), (j >= 4) ? 64'd1 : 64'd0);
      if (j < 8) chk("drain_pc", 64'(outEntry[63:32]), 64'(32'h200 + 32'(8*j)));
    end

    expPc = 32'h400;
    push(32'h400, 8'b0000_0011, 2'd0);
    push(32'h408, 8'b0000_0011, 2'd0);
    for (int j = 0; j < 10; j++) begin
      push(32'h410 + 32'(8*j), 8'b0000_0011, 2'd2);
      expPc = expPc + 32'd8;
      chk("wrap_count", 64'(count), 64'd4);
      chk("wrap_pc0", 64'(outEntry[63:32]), 64'(expPc));
      chk("wrap_pc1", 64'(outEntry[127:96]), 64'(expPc + 32'd4));
    end
    for (int j = 0; j < 4; j++) begin
      chk("wrap_tail", 64'(outEntry[63:32]), 64'(expPc + 32'(4*j)));
      pop(2'd1);
    end
    chk("wrap_empty", 64'(count), 64'd0);

    push(32'h500, 8'b0000_0111, 2'd0);
    load(32'h600, 8'b0001_1111, 2'd2);
    clear = 1'b1;
    #1;
    chk("clear_ready", 64'(inReady), 64'd0);
    step();
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_valid", 64'(outValid), 64'd0);
    chk("clear_entry", outEntry[63:0], 64'd0);

    push(32'h700, 8'b1111_0101, 2'd0);
    chk("nonthermo_count", 64'(count), 64'd1);
    chk("nonthermo_pc", 64'(outEntry[63:32]), 64'h700);
    load(32'h800, 8'b0000_0000, 2'd0);
    #1;
    chk("cut0_ready", 64'(inReady), 64'd1);
    step();
    chk("cut0_count", 64'(count), 64'd1);
    chk("cut0_pc", 64'(outEntry[63:32]), 64'h700);

    pop(2'd2);
    chk("clamp_count", 64'(count), 64'd0);
`ifdef NBJ_QUEUE_CHECK_EN
    chk("err_set", 64'(error), 64'd1);
    clear = 1'b1;
    step();
    chk("err_sticky", 64'(error), 64'd1);
`endif
    pop(2'd3);
    chk("clamp3_count", 64'(count), 64'd0);
    chk("clamp3_valid", 64'(outValid), 64'd0);

    push(32'hA00, 8'b0000_0111, 2'd0);
    chk("pre_async", 64'(count), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'(outValid), 64'd0);
`ifdef NBJ_QUEUE_CHECK_EN
    chk("err_reset", 64'(error), 64'd0);
`endif
    @(negedge clk) rst = 1'b1;
    push(32'hB00, 8'b0000_0001, 2'd0);
    chk("post_rst_count", 64'(count), 64'd1);
    chk("post_rst_pc", 64'(outEntry[63:32]), 64'hB00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/nbj_inst_queue.md
# nbj_inst_queue

Fetch-side instruction queue directly downstream of the next-branch-jump stage. It accepts one aligned fetch packet of up to eight 64-bit slots per cycle, keeps the slots that stage marks as surviving, and holds them in a circular buffer. It delivers up to two entries per cycle in program order to decode. A `clear` from the jump stage flushes all contents.

## Interface
Parameters:
- `DEPTH`, 16: number of 64-bit entries; must be a power of two and at least 8.
- `CW`, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_inValid`  in  1  a fetch packet is presented.
- `o_inReady`  out  1  the queue can accept a full packet.
- `i_alignedInstructionTableBus_512`  in  512  eight slots; slot k occupies bits [64k+63:64k]; each slot is {pc[31:0], instr[31:0]}.
- `i_cutPosition_8`  in  8  thermometer keep-mask from the jump stage.
- `i_clear`  in  1  synchronous flush.
- `o_outValid_2`  out  2  thermometer: 00, 01 or 11.
- `o_outEntry_128`  out  128  slot 0 at [63:0] is the oldest entry; slot 1 at [127:64].
- `i_deqCount_2`  in  2  number of entries decode consumes this cycle (0..2).
- `o_count`  out  CW  current occupancy.
- `o_error`  out  1  sticky protocol error; present only with NBJ_QUEUE_CHECK_EN.

## Operation
- Keep count n = number of consecutive 1s in `i_cutPosition_8` starting at bit 0. Bits above the first 0 are ignored, so 8'b0000_0111 gives n=3 and 8'b1111_0101 gives n=1.
- Enqueue fires when `i_inValid & o_inReady`. Slots 0..n-1 are written at wptr, wptr+1, … mod DEPTH, and wptr advances by n. A packet with n=0 is accepted and stores nothing.
- `o_inReady` = (DEPTH − count ≥ 8) & ~`i_clear`. It is conservative: a same-cycle dequeue earns no credit.
- Output: `o_outValid_2[0]` = (count≥1) and `o_outValid_2[1]` = (count≥2). `o_outEntry_128` shows entries at rptr and rptr+1 mod DEPTH. Any slot whose valid bit is 0 is driven to 0.
- Dequeue: rptr advances by `i_deqCount_2`, which the consumer must keep at or below popcount(`o_outValid_2`). Without the check macro, an illegal value is clamped to the number of valid entries.
- Next count = count + n(enq) − deq. Enqueue and dequeue in the same cycle are both honoured.
- Clear: on the next edge wptr, rptr and count become 0. Clear overrides enqueue and dequeue in the same cycle; the packet presented that cycle is dropped, and `o_inReady` is 0 during that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by count only.
- Storage RAM is not reset.

## Timing
- Reset values: wptr=0, rptr=0, count=0, `o_outValid_2`=00, `o_outEntry_128`=0, `o_inReady`=1, `o_error`=0.
- Enqueue-to-output latency is 1 cycle. An entry written at edge t is visible at `o_outEntry_128` after edge t when it is the oldest entry. There is no same-cycle bypass.
- Dequeue takes effect at the edge; the next entries appear right after it.
- `o_inReady` and `o_outValid_2` are functions of registered state only. The only combinational input path is `i_clear` → `o_inReady`.
- Reset asserted mid-operation clears all state immediately, regardless of the clock. The first enqueue is accepted on the first edge after `rst` deasserts.

## Configuration
- `NBJ_QUEUE_CHECK_EN` defined:
  - `o_error` exists.
  - `o_error` is set at the edge when `i_deqCount_2` > popcount(`o_outValid_2`), or when `i_deqCount_2` = 3.
  - It stays set until reset; `i_clear` does not clear it.
  - In these illegal cycles, dequeue is clamped exactly as in the unchecked build.
- Undefined: the `o_error` port and its logic are absent. Clamping is still applied.

## Test plan
- Reset, then a packet with cut 8'b0000_0111 and PCs 0x100/0x104/0x108 → next cycle count=3, outValid=11, entries 0x100 and 0x104. Then deq=2 → count=1, entry 0x108, outValid=01.
- DEPTH=16: two 8-slot packets with no dequeue → count=16 and inReady=0. Then deq=2 per cycle → inReady returns to 1 when count=8.
- Wrap-around: alternate enqueues and dequeues so wptr passes 15→0 → output order stays strictly by PC and no entry is lost or duplicated.
- Simultaneous enqueue (n=5), dequeue (2) and clear in one cycle → next cycle count=0, outValid=00; the packet is dropped.
- Non-thermometer cut 8'b1111_0101 → exactly 1 entry stored. A cut of 0 → packet accepted, count unchanged.
- With `NBJ_QUEUE_CHECK_EN`: count=1, deq=2 → o_error=1 and count=0. The error stays set after clear and drops only after `rst` is pulsed low.
